conv_psum_accumulator: RTL and testbench

- Producer side of the activation path: multiplies a stream of signed 8-bit activation/weight pairs and accumulates them with a bias into a BUF_WIDTH signed partial sum.
- After cfg_taps products, presents the sum on a valid/ready output. This is exactly the BUF_WIDTH value the downstream ReLU/requantizer consumes as its input.
- Sits between the line-buffer/weight-fetch logic and the ReLU stage, one instance per output channel lane.

---
 rtl/cnn_pkg.sv | 21 ++
 rtl/sat_add.sv | 33 +++
 rtl/conv_psum_accumulator.sv | 116 +++++++++++
 tb/tb_conv_psum_accumulator.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// cnn_pkg: definitions shared by the CNN datapath blocks (partial-sum
// accumulators, pooling, adder trees).
//   - CNN_DATA_WIDTH / CNN_BUF_WIDTH / CNN_TAP_WIDTH : default widths
//   - psum_state_e : control states of the partial-sum accumulator
//   - PSUM_MAX / PSUM_MIN : clamp bounds of a CNN_BUF_WIDTH signed sum
package cnn_pkg;

    localparam int CNN_DATA_WIDTH = 8;
    localparam int CNN_BUF_WIDTH  = 26;
    localparam int CNN_TAP_WIDTH  = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } psum_state_e;

    localparam logic signed [CNN_BUF_WIDTH-1:0] PSUM_MAX = {1'b0, {(CNN_BUF_WIDTH-1){1'b1}}};
    localparam logic signed [CNN_BUF_WIDTH-1:0] PSUM_MIN = {1'b1, {(CNN_BUF_WIDTH-1){1'b0}}};

endpackage

// File: rtl/sat_add.sv
// sat_add: combinational signed saturating adder.
//   a, b : WIDTH-bit signed operands
//   sum  : a + b clamped to [-2^(WIDTH-1), 2^(WIDTH-1)-1]
// The sum is formed one bit wider so that overflow shows up as a
// disagreement between the two top bits; the extra top bit is the true
// sign and selects which bound to clamp to.
module sat_add
    import cnn_pkg::*;
#(
    parameter int WIDTH = CNN_BUF_WIDTH
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] sum
);

    localparam logic signed [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic signed [WIDTH:0] wide;
    logic                  overflow;

    assign wide     = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    assign overflow = wide[WIDTH] != wide[WIDTH-1];

    always_comb begin
        sum = wide[WIDTH-1:0];
        if (overflow) begin
            sum = wide[WIDTH] ? SAT_MIN : SAT_MAX;
        end
    end

endmodule

// File: rtl/conv_psum_accumulator.sv
// conv_psum_accumulator: multiply-accumulate of signed activation/weight
// pairs plus a bias into a saturating BUF_WIDTH partial sum, presented on a
// valid/ready output after T accepted pairs (T = cfg_taps, 0 meaning 1).
//   clk, rst            : clock, synchronous active-high reset
//   cfg_taps, bias      : job config, sampled on the first beat of a job
//   in_valid / in_ready : act/wgt pair handshake (in_act, in_wgt)
//   out_valid/out_ready : result handshake, out_psum is the acc register
// While a result is held, in_ready follows out_ready so the first beat of
// the next job can be taken in the same cycle the result is consumed.
module conv_psum_accumulator
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = CNN_DATA_WIDTH,
    parameter int BUF_WIDTH  = CNN_BUF_WIDTH,
    parameter int TAP_WIDTH  = CNN_TAP_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic        [TAP_WIDTH-1:0]  cfg_taps,
    input  logic signed [BUF_WIDTH-1:0]  bias,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] in_act,
    input  logic signed [DATA_WIDTH-1:0] in_wgt,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [BUF_WIDTH-1:0]  out_psum
);

    psum_state_e                  state_reg;
    logic signed [BUF_WIDTH-1:0]  acc_reg;
    logic        [TAP_WIDTH-1:0]  cnt_reg;
    logic        [TAP_WIDTH-1:0]  taps_reg;
    logic                         out_valid_reg;

    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [BUF_WIDTH-1:0]    prod_ext;
    logic signed [BUF_WIDTH-1:0]    add_a;
    logic signed [BUF_WIDTH-1:0]    sum_sat;
    logic        [TAP_WIDTH-1:0]    taps_eff;
    logic                           accept;
    logic                           first_beat;
    logic                           last_beat;

    assign prod     = in_act * in_wgt;
    assign prod_ext = {{(BUF_WIDTH-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};

    assign taps_eff = (cfg_taps == '0) ? TAP_WIDTH'(1) : cfg_taps;

    // Outside ACC any accepted beat opens a new job (IDLE, or HOLD while
    // the held result is consumed in the same cycle).
    assign first_beat = (state_reg != ACC);
    assign last_beat  = (cnt_reg == taps_reg - TAP_WIDTH'(1));

    assign in_ready = !rst && ((state_reg != HOLD) || out_ready);
    assign accept   = in_valid && in_ready;

    // A new job starts from the bias, a running job from the accumulator.
    assign add_a = first_beat ? bias : acc_reg;

    sat_add #(
        .WIDTH (BUF_WIDTH)
    ) u_sat_add (
        .a   (add_a),
        .b   (prod_ext),
        .sum (sum_sat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            taps_reg      <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, HOLD: begin
                    if (accept) begin
                        acc_reg  <= sum_sat;
                        taps_reg <= taps_eff;
                        cnt_reg  <= TAP_WIDTH'(1);
                        if (taps_eff == TAP_WIDTH'(1)) begin
                            state_reg     <= HOLD;
                            out_valid_reg <= 1'b1;
                        end else begin
                            state_reg     <= ACC;
                            out_valid_reg <= 1'b0;
                        end
                    end else if (state_reg == HOLD && out_ready) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                    end
                end
                ACC: begin
                    if (accept) begin
                        acc_reg <= sum_sat;
                        cnt_reg <= cnt_reg + TAP_WIDTH'(1);
                        if (last_beat) begin
                            state_reg     <= HOLD;
                            out_valid_reg <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = out_valid_reg;
    assign out_psum  = acc_reg;

endmodule

// File: tb/tb_conv_psum_accumulator.sv
// Self-checking bench for conv_psum_accumulator. A job-level reference
// model (beat index within the job, running saturated sum, single held
// result slot) predicts out_valid, in_ready and out_psum every cycle.
// Directed jobs also pin the expected results to literal values.
module tb_conv_psum_accumulator;

    logic               clk;
    logic               rst;
    logic        [9:0]  cfg_taps;
    logic signed [25:0] bias;
    logic               in_valid;
    logic               in_ready;
    logic signed [7:0]  in_act;
    logic signed [7:0]  in_wgt;
    logic               out_valid;
    logic               out_ready;
    logic signed [25:0] out_psum;

    conv_psum_accumulator dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_taps  (cfg_taps),
        .bias      (bias),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_act    (in_act),
        .in_wgt    (in_wgt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_psum  (out_psum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // reference model
    localparam longint SUM_MAX = (longint'(1) <<< 25) - 1;
    localparam longint SUM_MIN = -(longint'(1) <<< 25);
    int     beat_idx = 0;
    int     t_cur    = 1;
    longint acc_m    = 0;
    bit     pend     = 0;
    longint pend_val = 0;
    int     n_out    = 0;

    // optional literal expectation for the next cycle
    bit     want_on  = 0;
    string  want_tag = "";
    longint want_val = 0;

    function automatic longint sat(input longint x);
        if (x > SUM_MAX) return SUM_MAX;
        if (x < SUM_MIN) return SUM_MIN;
        return x;
    endfunction

    task automatic check_val(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic expect_next(input string tag, input longint val);
        want_on  = 1;
        want_tag = tag;
        want_val = val;
    endtask

    // One clock cycle: drive inputs, check outputs against the model, then
    // advance the model by what this cycle's edge should do.
    task automatic step(input bit v, input int act, input int wgt,
                        input int taps, input longint b, input bit ordy);
        bit     take;
        longint prod;
        @(negedge clk);
        rst       = 1'b0;
        in_valid  = v;
        in_act    = act[7:0];
        in_wgt    = wgt[7:0];
        cfg_taps  = taps[9:0];
        bias      = b[25:0];
        out_ready = ordy;
        #1;
        check_val("out_valid", out_valid, pend);
        check_val("in_ready", in_ready, (!pend || ordy));
        if (pend) check_val("out_psum", out_psum, pend_val);
        if (want_on) begin
            check_val({want_tag, "_valid"}, out_valid, 1);
            check_val(want_tag, out_psum, want_val);
            want_on = 0;
        end
        take = v && (!pend || ordy);
        if (pend && ordy) begin
            $display("out #%0d psum=%0d", n_out, pend_val);
            n_out++;
            pend = 0;
        end
        if (take) begin
            prod = longint'(act) * longint'(wgt);
            if (beat_idx == 0) begin
                t_cur = (taps == 0) ? 1 : taps;
                acc_m = sat(b + prod);
            end else begin
                acc_m = sat(acc_m + prod);
            end
            beat_idx++;
            if (beat_idx == t_cur) begin
                pend     = 1;
                pend_val = acc_m;
                beat_idx = 0;
            end
        end
    endtask

    task automatic do_reset(input int n, input bit v);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst       = 1'b1;
            in_valid  = v;
            in_act    = 8'($urandom);
            in_wgt    = 8'($urandom);
            cfg_taps  = 10'd1;
            bias      = 26'd7;
            out_ready = 1'($urandom_range(0, 1));
            #1;
            check_val("rst_in_ready", in_ready, 0);
            if (i > 0) begin
                check_val("rst_out_valid", out_valid, 0);
                check_val("rst_out_psum", out_psum, 0);
            end
        end
        pend     = 0;
        beat_idx = 0;
        want_on  = 0;
    endtask

    initial begin
        longint b;
        int     taps;
        int     mode;
        rst = 1'b1; in_valid = 1'b0; in_act = '0; in_wgt = '0;
        cfg_taps = '0; bias = '0; out_ready = 1'b0;

        // reset with beats presented: none of them may produce output
        do_reset(3, 1'b1);
        step(0, 0, 0, 1, 0, 1);
        step(0, 0, 0, 1, 0, 1);

        // basic 3-tap job: 10 + 6 - 20 - 7 = -11
        step(1, 2, 3, 3, 10, 1);
        step(1, -4, 5, 9, 999, 1);
        step(1, 7, -1, 9, 999, 1);
        expect_next("basic3", -11);
        step(0, 0, 0, 1, 0, 1);

        // backpressure: result held 5 cycles while a pair waits
        step(1, 2, 3, 3, 10, 1);
        step(1, -4, 5, 3, 10, 1);
        step(1, 7, -1, 3, 10, 1);
        for (int i = 0; i < 5; i++) begin
            expect_next("bp_hold", -11);
            step(1, 1, 1, 1, 0, 0);
        end
        expect_next("bp_release", -11);
        step(1, 1, 1, 1, 0, 1);
        expect_next("bp_next", 1);
        step(0, 0, 0, 1, 0, 1);

        // back-to-back 2-tap jobs: 5 then 9, no bubble
        step(1, 1, 1, 2, 0, 1);
        step(1, 2, 2, 5, 77, 1);
        expect_next("b2b_first", 5);
        step(1, 3, 3, 2, 1, 1);
        step(1, -1, 1, 5, 77, 1);
        expect_next("b2b_second", 9);
        step(0, 0, 0, 1, 0, 1);

        // positive and negative saturation
        step(1, 127, 127, 2, (longint'(1) <<< 25) - 100, 1);
        step(1, 1, 1, 2, 0, 1);
        expect_next("sat_pos", 33554431);
        step(1, -128, 127, 1, -(longint'(1) <<< 25) + 10, 1);
        expect_next("sat_neg", -33554432);
        step(0, 0, 0, 1, 0, 1);

        // cfg_taps == 0 behaves as one tap
        step(1, 1, 1, 0, 5, 1);
        expect_next("taps0", 6);
        step(0, 0, 0, 1, 0, 1);

        // reset after 2 of 4 beats discards the partial sum
        step(1, 5, 5, 4, 100, 1);
        step(1, 6, 6, 4, 100, 1);
        do_reset(1, 1'b0);
        step(1, 3, 4, 1, 0, 1);
        expect_next("post_rst", 12);
        step(0, 0, 0, 1, 0, 1);
        step(0, 0, 0, 1, 0, 1);

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset($urandom_range(1, 3), 1'($urandom_range(0, 1)));
            end else begin
                mode = $urandom_range(0, 3);
                if (mode == 0)      b = SUM_MAX - longint'($urandom_range(0, 40000));
                else if (mode == 1) b = SUM_MIN + longint'($urandom_range(0, 40000));
                else                b = longint'($urandom_range(0, 2000)) - 1000;
                taps = (beat_idx == 0) ? $urandom_range(0, 6) : $urandom_range(0, 1023);
                step($urandom_range(0, 3) != 0,
                     $urandom_range(0, 255) - 128,
                     $urandom_range(0, 255) - 128,
                     taps, b,
                     $urandom_range(0, 3) != 0);
            end
        end

        // drain any held result
        step(0, 0, 0, 1, 0, 1);
        step(0, 0, 0, 1, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
